measurement_counters: RTL

//   Counter bank on the receiving end of the measurement sequencer's counter interface.
//   - Consumes the phase strobes and the measurement enable/clear.
//   - Returns cycle_count, pulse_count and measurement_count to the sequencer.
//   - Latches each finished dual-slope result (count + polarity) and hands it to the MCU

---
 rtl/voltmeter_pkg.sv | 20 ++
 rtl/sat_counter.sv | 68 ++++++
 rtl/measurement_counters.sv | 115 +++++++++++
 3 files changed

// File: rtl/voltmeter_pkg.sv
// Shared widths, limits and the latched-result record for the dual-slope
// measurement counter bank.
package voltmeter_pkg;

   localparam int PULSE_W    = 10;
   localparam int MEAS_W     = 12;
   localparam int CYCLE_W    = 5;
   localparam int INT_PULSES = 1000;
   localparam int CYCLES_MAX = 24;

   localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(INT_PULSES - 1);
   localparam logic [MEAS_W-1:0]  MEAS_LAST  = {MEAS_W{1'b1}};
   localparam logic [CYCLE_W-1:0] CYCLE_LAST = CYCLE_W'(CYCLES_MAX);

   typedef struct packed {
      logic              sign;
      logic [MEAS_W-1:0] count;
   } result_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with clear priority that either wraps to zero or sticks at max_i;
// sat_o is a sticky flag raised when a saturating count reaches max_i.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         clear_i,
   input  logic         enable_i,
   input  logic         saturate_i,
   input  logic [W-1:0] max_i,
   output logic [W-1:0] count_o,
   output logic         sat_o
);

   logic [W-1:0] count_r;
   logic         sat_r;
   logic [W-1:0] count_inc_s;
   logic [W-1:0] count_next_s;
   logic         sat_next_s;

   assign count_inc_s = count_r + {{(W-1){1'b0}}, 1'b1};

   // Next-state selection: clear, then enable with wrap or saturate at max_i.
   always_comb begin
      count_next_s = count_r;
      sat_next_s   = sat_r;
      if (clear_i) begin
         count_next_s = {W{1'b0}};
         sat_next_s   = 1'b0;
      end else if (enable_i) begin
         if (count_r == max_i) begin
            if (saturate_i) begin
               count_next_s = max_i;
               sat_next_s   = 1'b1;
            end else begin
               count_next_s = {W{1'b0}};
               sat_next_s   = sat_r;
            end
         end else begin
            count_next_s = count_inc_s;
            if (saturate_i && (count_inc_s == max_i)) begin
               sat_next_s = 1'b1;
            end else begin
               sat_next_s = sat_r;
            end
         end
      end else begin
         count_next_s = count_r;
         sat_next_s   = sat_r;
      end
   end

   // Count and flag registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_r <= {W{1'b0}};
         sat_r   <= 1'b0;
      end else begin
         count_r <= count_next_s;
         sat_r   <= sat_next_s;
      end
   end

   assign count_o = count_r;
   assign sat_o   = sat_r;

endmodule

// File: rtl/measurement_counters.sv
// Counter bank behind the measurement sequencer: pulse, measurement and cycle
// counters plus a valid/ack latch that hands finished results to the MCU.
module measurement_counters
   import voltmeter_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               idle_i,
   input  logic               integrate_i,
   input  logic               deintegrate_i,
   input  logic               ref_sign_i,
   input  logic               measurement_en_i,
   input  logic               measurement_clear_i,
   input  logic               result_ack_i,
   output logic [CYCLE_W-1:0] cycle_count_o,
   output logic [PULSE_W-1:0] pulse_count_o,
   output logic [MEAS_W-1:0]  measurement_count_o,
   output logic [MEAS_W-1:0]  result_o,
   output logic               result_sign_o,
   output logic               result_valid_o,
   output logic               overflow_o,
   output logic               overrun_o
);

   logic               int_q_r;
   logic               deint_q_r;
   logic               sign_q_r;
   logic               int_rise_s;
   logic               deint_fall_s;
   logic               pulse_sat_unused_s;
   logic [CYCLE_W-1:0] cycle_r;
   result_t            result_r;
   logic               valid_r;
   logic               overrun_r;

   assign int_rise_s   = integrate_i & ~int_q_r;
   assign deint_fall_s = ~deintegrate_i & deint_q_r;

   // Phase history for edge detection; the sign rides along so the capture
   // sees the polarity of the final deintegrate cycle.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         int_q_r   <= 1'b0;
         deint_q_r <= 1'b0;
         sign_q_r  <= 1'b0;
      end else begin
         int_q_r   <= integrate_i;
         deint_q_r <= deintegrate_i;
         sign_q_r  <= ref_sign_i;
      end
   end

   sat_counter #(.W(PULSE_W)) u_pulse_counter (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .clear_i    (idle_i | int_rise_s),
      .enable_i   (integrate_i),
      .saturate_i (1'b0),
      .max_i      (PULSE_LAST),
      .count_o    (pulse_count_o),
      .sat_o      (pulse_sat_unused_s)
   );

   sat_counter #(.W(MEAS_W)) u_meas_counter (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .clear_i    (measurement_clear_i),
      .enable_i   (measurement_en_i),
      .saturate_i (1'b1),
      .max_i      (MEAS_LAST),
      .count_o    (measurement_count_o),
      .sat_o      (overflow_o)
   );

   // Completed-measurement index within a burst.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cycle_r <= {CYCLE_W{1'b0}};
      end else if (idle_i) begin
         cycle_r <= {CYCLE_W{1'b0}};
      end else if (deint_fall_s) begin
         cycle_r <= (cycle_r == CYCLE_LAST) ? {CYCLE_W{1'b0}} : cycle_r + {{(CYCLE_W-1){1'b0}}, 1'b1};
      end else begin
         cycle_r <= cycle_r;
      end
   end

   // Result latch; a same-cycle ack retires the old result so no overrun.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         result_r  <= '{sign: 1'b0, count: {MEAS_W{1'b0}}};
         valid_r   <= 1'b0;
         overrun_r <= 1'b0;
      end else if (deint_fall_s) begin
         result_r  <= '{sign: sign_q_r, count: measurement_count_o};
         valid_r   <= 1'b1;
         overrun_r <= (valid_r & ~result_ack_i) | (overrun_r & ~(valid_r & result_ack_i));
      end else if (valid_r && result_ack_i) begin
         result_r  <= result_r;
         valid_r   <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         result_r  <= result_r;
         valid_r   <= valid_r;
         overrun_r <= overrun_r;
      end
   end

   assign cycle_count_o  = cycle_r;
   assign result_o       = result_r.count;
   assign result_sign_o  = result_r.sign;
   assign result_valid_o = valid_r;
   assign overrun_o      = overrun_r;

endmodule
